// File: rtl/jt49_mch_pkg.sv
// Shared register map and per-address read masks for the jt49_mch tone generator.
package jt49_mch_pkg;

  localparam int unsigned A_PERIOD = 32'h00;
  localparam int unsigned A_NOISE  = 32'h10;
  localparam int unsigned A_TDIS   = 32'h11;
  localparam int unsigned A_NDIS   = 32'h12;
  localparam int unsigned A_VOL    = 32'h18;
  localparam int unsigned NREGS    = 32;

  // Bits that exist at each address; everything else stores and reads as 0.
  function automatic logic [7:0] rd_mask(input logic [4:0] a, input int unsigned ch,
                                         input int unsigned pw);
    int unsigned ai;
    int unsigned bits;
    logic [7:0]  m;
    ai = {27'd0, a};
    m  = '0;
    if (ai < A_PERIOD + 2 * ch) begin
      bits = a[0] ? pw - 8 : 8;
      m    = 8'((32'd1 << bits) - 32'd1);
    end else if (ai == A_NOISE) begin
      m = 8'h1F;
    end else if (ai == A_TDIS || ai == A_NDIS) begin
      m = 8'((32'd1 << ch) - 32'd1);
    end else if (ai >= A_VOL && ai < A_VOL + ch) begin
      m = 8'h0F;
    end
    return m;
  endfunction

endpackage

// File: rtl/jt49_mch_tone.sv
// Single tone divider: toggles its square output every max(period,1) ticks.
module jt49_mch_tone #(
  parameter int unsigned PW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [PW-1:0] period,
  output logic          square
);

  logic [PW-1:0] r_cnt;
  logic          r_sq;
  logic [PW-1:0] w_last;

  // >= rather than == so a period shrunk below the running count wraps at once.
  assign w_last = (period == '0) ? '0 : period - PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (tick) begin
      if (r_cnt >= w_last) begin
        r_cnt <= '0;
        r_sq  <= ~r_sq;
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
    end
  end

  assign square = r_sq;

endmodule

// File: rtl/jt49_mch.sv
// Multi-channel PSG-style tone/noise generator with byte-wide register bus.
module jt49_mch
  import jt49_mch_pkg::*;
#(
  parameter int unsigned CH = 3,
  parameter int unsigned PW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            cs_n,
  input  logic            wr_n,
  input  logic [4:0]      addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic [4*CH-1:0] level,
  output logic [6:0]      sound
);

  logic [7:0]      r_reg [NREGS];
  logic [7:0]      r_dout;
  logic [2:0]      r_pre;
  logic [5:0]      r_ndiv;
  logic [16:0]     r_lfsr;
  logic [4*CH-1:0] r_level;
  logic [6:0]      r_sound;

  logic            w_tick;
  logic [4:0]      w_np;
  logic [5:0]      w_nlast;
  logic [CH-1:0]   w_sq;
  logic [CH-1:0]   w_tdis;
  logic [CH-1:0]   w_ndis;
  logic [CH-1:0]   w_mix;
  logic [6:0]      w_sum;

  // Storage is kept pre-masked, so a raw read already returns 0 for absent bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout <= '0;
      for (int unsigned i = 0; i < NREGS; i++) r_reg[i] <= '0;
    end else if (!cs_n) begin
      r_dout <= r_reg[addr];
      if (!wr_n) r_reg[addr] <= din & rd_mask(addr, CH, PW);
    end
  end

  assign w_tick  = clk_en & (r_pre == 3'd7);
  assign w_np    = r_reg[A_NOISE][4:0];
  assign w_nlast = (w_np == '0) ? 6'd1 : {w_np, 1'b0} - 6'd1;
  assign w_tdis  = r_reg[A_TDIS][CH-1:0];
  assign w_ndis  = r_reg[A_NDIS][CH-1:0];
  assign w_mix   = (w_sq | w_tdis) & ({CH{r_lfsr[0]}} | w_ndis);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [PW-1:0] w_period;
    assign w_period = {r_reg[A_PERIOD + 2*g + 1][PW-9:0], r_reg[A_PERIOD + 2*g]};
    jt49_mch_tone #(.PW(PW)) u_tone (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (w_tick),
      .period (w_period),
      .square (w_sq[g])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned n = 0; n < CH; n++) w_sum = w_sum + {3'd0, r_level[4*n +: 4]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_ndiv  <= '0;
      r_lfsr  <= 17'd1;
      r_level <= '0;
      r_sound <= '0;
    end else if (clk_en) begin
      r_pre <= r_pre + 3'd1;
      if (w_tick) begin
        if (r_ndiv >= w_nlast) begin
          r_ndiv <= '0;
          r_lfsr <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
        end else begin
          r_ndiv <= r_ndiv + 6'd1;
        end
      end
      for (int unsigned n = 0; n < CH; n++)
        r_level[4*n +: 4] <= w_mix[n] ? r_reg[A_VOL + n][3:0] : 4'd0;
      r_sound <= w_sum;
    end
  end

  assign dout  = r_dout;
  assign level = r_level;
  assign sound = r_sound;

endmodule

// File: doc/jt49_mch.md
JT49_MCH -- requirements
Module: jt49_mch

Interface
REQ-001 SHALL have parameter CH, default 3, meaning number of tone channels (legal range 1..8).
REQ-002 SHALL have parameter PW, default 12, meaning tone period width in bits (legal range 9..16).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port clk_en  input  1  clock enable; all sound timing advances only on cycles with clk_en=1.
REQ-006 SHALL have port cs_n  input  1  bus chip select, active-low.
REQ-007 SHALL have port wr_n  input  1  bus write strobe, active-low, qualified by cs_n.
REQ-008 SHALL have port addr  input  5  register address.
REQ-009 SHALL have port din  input  8  write data.
REQ-010 SHALL have port dout  output  8  registered read data.
REQ-011 SHALL have port level  output  4*CH  per-channel linear level, channel n at bits [4n+3:4n].
REQ-012 SHALL have port sound  output  7  registered sum of all channel levels.

Function
REQ-013 Register map: 2n = period low byte of channel n; 2n+1 = period bits [PW-1:8] of channel n; 0x10 = noise period (5 bits); 0x11 = tone disable mask (CH bits); 0x12 = noise disable mask (CH bits); 0x18+n = volume of channel n (4 bits).
REQ-014 Unimplemented addresses and bits SHALL ignore writes and read as 0.
REQ-015 On a cycle with cs_n=0: dout <= masked register[addr], sampled before any write in that cycle; if wr_n=0, register[addr] <= din (masked); bus access is independent of clk_en.
REQ-016 Prescaler: 3-bit counter increments on clk_en; tick asserted for one clk_en cycle when the counter wraps 7->0 (one tick per 8 clk_en).
REQ-017 Per channel, on tick: if cnt >= eff_period-1 then cnt <= 0 and square output toggles, else cnt <= cnt+1; eff_period = max(period,1).
REQ-018 Period rewritten mid-count below current cnt SHALL cause wrap at the next tick (no full 2^PW rollover).
REQ-019 Noise: 17-bit LFSR, seed 1, next = {lfsr[0]^lfsr[3], lfsr[16:1]}; advances once every 2*max(noise_period,1) ticks; noise bit = lfsr[0].
REQ-020 Mix per channel: mix = (square | tone_dis[n]) & (noise | noise_dis[n]); both disabled gives constant 1.
REQ-021 On clk_en: level[n] <= mix ? volume[n] : 0; sound <= sum of current level outputs (one clk_en cycle behind level).
REQ-022 A write of 1 to bit n of 0x11 SHALL take effect on the next clk_en level update; counters keep running.
REQ-023 When clk_en=0 all counters, LFSR, level and sound SHALL hold.

Reset
REQ-024 With rst_n=0 at a rising edge: all registers 0, dout 0, level 0, sound 0, prescaler 0, all cnt 0, all squares 0, LFSR 1, noise divider 0; reset overrides bus access.
REQ-025 Reset asserted mid-period SHALL abandon the period; first toggle after release follows REQ-017 from cnt=0.

Structure
REQ-026 Register address constants (period base, 0x10, 0x11, 0x12, 0x18) and per-address read masks SHALL live in a shared package jt49_mch_pkg.
REQ-027 Per-channel divider SHALL be one sub-module jt49_mch_tone (inputs clk, rst_n, tick, period; output square), instantiated CH times via generate.
REQ-028 sound width 7 is fixed; max 8*15=120 fits without overflow.

Verification
REQ-029 Write 0x0A to addr 0x18, read 0x18 -> dout=0x0A one cycle after cs_n low; write 0xFF to 0x18 -> read 0x0F.
REQ-030 CH=3, clk_en=1 constant, period0=1, vol0=15, 0x11=0x00, 0x12=0x07 -> level[3:0] toggles 0/15 every 8 clk; period0=4 -> every 32 clk.
REQ-031 Period0=0 vs period0=1 -> identical square waveform.
REQ-032 0x11=0x07, 0x12=0x07, vols 5,6,7 -> levels constant 5,6,7, sound=18 after two clk_en cycles.
REQ-033 0x11=0x07, 0x12=0x06, noise period 1 -> channel 0 follows LFSR bit 0 from seed 1, stepping every 16 clk_en.
REQ-034 rst_n low mid-period with period0=100 -> all outputs 0 next edge; after release first toggle 800 clk_en later.
